dmem_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_region_decode.sv | 45 ++++
 rtl/dmem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and address-map helpers for the data-space controller.
// Region limits are functions so every parameterisation derives them the same way.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REG  = 2'd0,
    IO   = 2'd1,
    SRAM = 2'd2,
    ERR  = 2'd3
  } region_t;

  function automatic int sram_base(int num_regs, int num_io);
    return num_regs + num_io;
  endfunction

  function automatic int sram_last(int num_regs, int num_io, int sram_bytes);
    return num_regs + num_io + sram_bytes - 1;
  endfunction

endpackage

// File: rtl/dmem_region_decode.sv
// Combinational decode of one byte address into register, IO, SRAM or error.
// In IO-only form the address is an IO index and never reaches registers or SRAM.
module dmem_region_decode
  import dmem_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int NUM_IO     = 64,
  parameter int SRAM_BYTES = 2048,
  parameter int SRAM_AW    = 11
) (
  input  logic [15:0]        a,
  input  logic               io_only,
  output region_t            region,
  output logic [15:0]        index,
  output logic [SRAM_AW-1:0] sram_off
);

  localparam int unsigned SRAM_BASE = sram_base(NUM_REGS, NUM_IO);
  localparam int unsigned SRAM_LAST = sram_last(NUM_REGS, NUM_IO, SRAM_BYTES);

  logic [31:0] ai;

  always_comb begin
    region   = ERR;
    index    = '0;
    sram_off = '0;
    ai       = {16'h0000, a};
    if (io_only) begin
      if (ai < 32'(NUM_IO)) begin
        region = IO;
        index  = a;
      end
    end else if (ai < 32'(NUM_REGS)) begin
      region = REG;
      index  = a;
    end else if (ai < SRAM_BASE) begin
      region = IO;
      index  = 16'(ai - 32'(NUM_REGS));
    end else if (ai <= SRAM_LAST) begin
      region   = SRAM;
      sram_off = SRAM_AW'(ai - SRAM_BASE);
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-space controller: sequences byte and 16-bit little-endian accesses into
// the GP register file, IO register file and external SRAM, one byte at a time.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int NUM_IO     = 64,
  parameter int SRAM_BYTES = 2048,
  parameter int SRAM_AW    = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic                  wide,
  input  logic                  io_only,
  input  logic [15:0]           addr,
  input  logic [15:0]           wdata,
  input  logic [NUM_REGS*8-1:0] register_bus,
  input  logic [NUM_IO*8-1:0]   io_bus,
  input  logic [7:0]            sram_q,
  output logic                  ready,
  output logic                  rvalid,
  output logic [15:0]           rdata,
  output logic                  err,
  output logic [NUM_REGS-1:0]   reg_we,
  output logic [NUM_IO-1:0]     io_we,
  output logic [7:0]            write_data,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic                  sram_wren,
  output logic [1:0]            state_dbg
);

  // Handshake: a request is taken on any rising edge where req && ready; ready is
  // high only while idle, so req during a busy access is simply not seen. Completion
  // is a single-cycle rvalid pulse with err and rdata valid alongside it; there is
  // no back-pressure on the response side.

  state_t  state, state_nxt;
  logic    byte_sel;
  logic    err_acc;
  logic    lat_we, lat_wide, lat_io;
  logic [15:0] lat_addr, lat_wdata;

  logic [15:0]        byte_addr;
  region_t            region;
  logic [15:0]        dec_index;
  logic [SRAM_AW-1:0] dec_off;
  logic [7:0]         cap_byte;
  logic [7:0]         wr_byte;
  logic               do_write;

  assign byte_addr = lat_addr + {15'b0, byte_sel};
  assign state_dbg = state;

  dmem_region_decode #(
    .NUM_REGS  (NUM_REGS),
    .NUM_IO    (NUM_IO),
    .SRAM_BYTES(SRAM_BYTES),
    .SRAM_AW   (SRAM_AW)
  ) u_decode (
    .a       (byte_addr),
    .io_only (lat_io),
    .region  (region),
    .index   (dec_index),
    .sram_off(dec_off)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_sel  <= 1'b0;
      err_acc   <= 1'b0;
      rdata     <= '0;
      lat_we    <= 1'b0;
      lat_wide  <= 1'b0;
      lat_io    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_wide  <= wide;
            lat_io    <= io_only;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            byte_sel  <= 1'b0;
            err_acc   <= 1'b0;
          end
        end
        CAPTURE: begin
          // The low-byte capture also clears the high byte, so byte accesses read 0 there.
          if (byte_sel) rdata[15:8] <= cap_byte;
          else          rdata       <= {8'h00, cap_byte};
          if (region == ERR) err_acc <= 1'b1;
          if (lat_wide && !byte_sel) byte_sel <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = (lat_wide && !byte_sel) ? ISSUE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read byte source; writes and error bytes contribute 0x00.
  always_comb begin
    cap_byte = 8'h00;
    if (!lat_we) begin
      case (region)
        REG: begin
          for (int i = 0; i < NUM_REGS; i++)
            if (dec_index == 16'(i)) cap_byte = register_bus[i*8 +: 8];
        end
        IO: begin
          for (int i = 0; i < NUM_IO; i++)
            if (dec_index == 16'(i)) cap_byte = io_bus[i*8 +: 8];
        end
        SRAM:    cap_byte = sram_q;
        default: cap_byte = 8'h00;
      endcase
    end
  end

  // Strobes come only from registered state and are cut immediately by reset.
  always_comb begin
    ready      = (state == IDLE);
    rvalid     = rst_n && (state == DONE);
    err        = rst_n && (state == DONE) && err_acc;
    reg_we     = '0;
    io_we      = '0;
    sram_wren  = 1'b0;
    write_data = 8'h00;
    sram_addr  = '0;
    wr_byte    = byte_sel ? lat_wdata[15:8] : lat_wdata[7:0];
    do_write   = rst_n && (state == ISSUE) && lat_we;
    if (region == SRAM) sram_addr = dec_off;
    if (do_write && (region != ERR)) begin
      write_data = wr_byte;
      case (region)
        REG: begin
          for (int i = 0; i < NUM_REGS; i++)
            if (dec_index == 16'(i)) reg_we[i] = 1'b1;
        end
        IO: begin
          for (int i = 0; i < NUM_IO; i++)
            if (dec_index == 16'(i)) io_we[i] = 1'b1;
        end
        SRAM:    sram_wren = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: storage models driven by the strobes, a flat data-space
// reference array, directed address-map corners and randomized accesses.
module tb_dmem_ctrl;

  localparam int NR   = 32;
  localparam int NIO  = 64;
  localparam int SB   = 2048;
  localparam int AW   = 11;
  localparam int BASE = NR + NIO;
  localparam int LAST = BASE + SB - 1;

  // clock / reset and DUT signals
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, we = 1'b0, wide = 1'b0, io_only = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic [NR*8-1:0]  register_bus;
  logic [NIO*8-1:0] io_bus;
  logic [7:0]       sram_q;
  logic ready, rvalid, err, sram_wren;
  logic [15:0] rdata;
  logic [NR-1:0]  reg_we;
  logic [NIO-1:0] io_we;
  logic [7:0]     write_data;
  logic [AW-1:0]  sram_addr;
  logic [1:0]     state_dbg;

  always #5 clk = ~clk;

  dmem_ctrl #(.NUM_REGS(NR), .NUM_IO(NIO), .SRAM_BYTES(SB), .SRAM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wide(wide), .io_only(io_only),
    .addr(addr), .wdata(wdata), .register_bus(register_bus), .io_bus(io_bus),
    .sram_q(sram_q), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err),
    .reg_we(reg_we), .io_we(io_we), .write_data(write_data), .sram_addr(sram_addr),
    .sram_wren(sram_wren), .state_dbg(state_dbg)
  );

  // storage blocks around the controller
  logic [7:0] reg_mem  [NR];
  logic [7:0] io_mem   [NIO];
  logic [7:0] sram_mem [SB];

  for (genvar g = 0; g < NR; g++)  begin : g_rb assign register_bus[g*8 +: 8] = reg_mem[g]; end
  for (genvar g = 0; g < NIO; g++) begin : g_ib assign io_bus[g*8 +: 8] = io_mem[g]; end

  always @(posedge clk) begin
    sram_q <= sram_mem[sram_addr];
    if (sram_wren) sram_mem[sram_addr] <= write_data;
    for (int i = 0; i < NR; i++)  if (reg_we[i]) reg_mem[i] <= write_data;
    for (int i = 0; i < NIO; i++) if (io_we[i])  io_mem[i]  <= write_data;
  end

  // reference model: one flat byte array over the whole data space
  logic [7:0]  ref_data [LAST+1];
  logic [23:0] exp_q[$];
  logic [23:0] act_q[$];
  int n_vec = 0;
  int n_err = 0;
  int multi_hot = 0;

  // strobe monitor: every strobe-cycle becomes {data address, byte}
  always @(negedge clk) begin
    int hot;
    hot = 0;
    for (int i = 0; i < NR; i++)
      if (reg_we[i]) begin act_q.push_back({16'(i), write_data}); hot++; end
    for (int i = 0; i < NIO; i++)
      if (io_we[i]) begin act_q.push_back({16'(NR + i), write_data}); hot++; end
    if (sram_wren) begin act_q.push_back({16'(BASE) + 16'(sram_addr), write_data}); hot++; end
    if (hot > 1) multi_hot++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic preload(input int sa, input logic [7:0] v);
    ref_data[sa] = v;
    if (sa < NR)        reg_mem[sa] <= v;
    else if (sa < BASE) io_mem[sa - NR] <= v;
    else                sram_mem[sa - BASE] <= v;
  endtask

  // expected result of an access, plus the strobes it must produce
  task automatic model(input logic w, input logic wd, input logic io, input logic [15:0] a,
                       input logic [15:0] d, output logic [15:0] er, output logic ee);
    er = '0;
    ee = 1'b0;
    for (int k = 0; k < (wd ? 2 : 1); k++) begin
      logic [15:0] ba;
      int sa;
      logic ok;
      ba = a + 16'(k);
      if (io) begin ok = (int'(ba) < NIO); sa = NR + int'(ba); end
      else    begin ok = (int'(ba) <= LAST); sa = int'(ba); end
      if (!ok) ee = 1'b1;
      else if (w) begin
        exp_q.push_back({16'(sa), d[8*k +: 8]});
        ref_data[sa] = d[8*k +: 8];
      end else er[8*k +: 8] = ref_data[sa];
    end
  endtask

  // driver: called on a falling edge with the controller idle
  task automatic access(input logic w, input logic wd, input logic io, input logic [15:0] a,
                        input logic [15:0] d, input bit poke);
    logic [15:0] er;
    logic ee;
    int lat;
    bit early;
    model(w, wd, io, a, d, er, ee);
    lat = wd ? 5 : 3;
    check_val("ready_before", ready, 1);
    req = 1'b1; we = w; wide = wd; io_only = io; addr = a; wdata = d;
    @(posedge clk);
    early = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      if (poke && c == 2) begin req = 1'b1; we = 1'b1; addr = 16'($urandom); wdata = 16'($urandom); end
      if (poke && c == 3) req = 1'b0;
      if (c < lat && (rvalid || ready)) early = 1'b1;
      if (c == lat) begin
        check_val("rvalid", rvalid, 1);
        check_val("rdata", rdata, er);
        check_val("err", err, ee);
        check_val("ready_busy", ready, 0);
      end
      if (c == lat + 1) begin
        check_val("ready_after", ready, 1);
        check_val("rvalid_pulse", rvalid, 0);
      end
    end
    check_val("early_resp", early, 0);
    check_val("n_strobes", act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0)
      check_val("strobe", act_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < NR; i++)  begin reg_mem[i] = 8'($urandom);  ref_data[i] = reg_mem[i]; end
    for (int i = 0; i < NIO; i++) begin io_mem[i] = 8'($urandom);   ref_data[NR+i] = io_mem[i]; end
    for (int i = 0; i < SB; i++)  begin sram_mem[i] = 8'($urandom); ref_data[BASE+i] = sram_mem[i]; end

    repeat (3) @(negedge clk);
    check_val("rst_ready", ready, 1);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_err", err, 0);
    check_val("rst_reg_we", reg_we, 0);
    check_val("rst_io_we", 32'(io_we != '0), 0);
    check_val("rst_sram_wren", sram_wren, 0);
    check_val("rst_wdata", write_data, 0);
    check_val("rst_sram_addr", sram_addr, 0);
    rst_n = 1'b1;

    // address-map corners
    preload(5, 8'hA7);
    access(0, 0, 0, 16'h0005, 16'h0000, 0);
    access(1, 0, 0, 16'h0030, 16'h003C, 0);
    access(0, 0, 0, 16'h0030, 16'h0000, 0);
    access(1, 1, 0, 16'h0100, 16'hBEEF, 0);
    access(0, 1, 0, 16'h0100, 16'h0000, 0);
    preload(LAST, 8'h11);
    access(0, 1, 0, 16'h085F, 16'h0000, 0);
    access(1, 1, 0, 16'h085F, 16'h5A66, 0);
    access(0, 0, 0, 16'h085F, 16'h0000, 0);
    access(0, 0, 1, 16'h003F, 16'h0000, 0);
    access(0, 0, 1, 16'h0040, 16'h0000, 0);
    access(0, 1, 0, 16'h005F, 16'h0000, 0);
    access(0, 1, 0, 16'h001F, 16'h0000, 0);
    access(0, 1, 0, 16'hFFFF, 16'h0000, 0);
    access(1, 1, 0, 16'hFFFF, 16'h1234, 0);
    access(0, 0, 0, 16'h0000, 16'h0000, 0);
    access(0, 1, 0, 16'h0200, 16'h0000, 1);
    access(1, 0, 0, 16'h0300, 16'h00C3, 1);

    // reset during ISSUE of a write aborts it
    req = 1'b1; we = 1'b1; wide = 1'b1; io_only = 1'b0; addr = 16'h0150; wdata = 16'hA55A;
    @(posedge clk);
    #2 rst_n = 1'b0; req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_ready", ready, 1);
    check_val("abort_rvalid", rvalid, 0);
    rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      repeat (6) begin @(negedge clk); if (rvalid) seen = 1'b1; end
      check_val("abort_no_rvalid", seen, 0);
    end
    check_val("abort_no_strobe", act_q.size(), 0);
    access(0, 1, 0, 16'h0150, 16'h0000, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      logic io;
      io = 1'b0;
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(0, LAST + 10));
        1: begin io = 1'b1; a = 16'($urandom_range(0, NIO + 6)); end
        2: case ($urandom_range(0, 3))
             0: a = 16'(NR - 1);
             1: a = 16'(BASE - 1);
             2: a = 16'(LAST);
             default: a = 16'hFFFF;
           endcase
        default: a = 16'($urandom);
      endcase
      access(1'($urandom), 1'($urandom), io, a, 16'($urandom), $urandom_range(0, 4) == 0);
    end

    check_val("one_hot", multi_hot, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
